// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: state encoding, register file layout and reset image of the FPU issue sequencer
package fpu_issue_ctrl_pkg;

    import river_cfg_pkg::*;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam int waddr_width_max = 16;
    localparam int wdog_width_max = 10;
    localparam logic [4:0] ex_timeout = 5'b10000;

    typedef struct packed {
        state_e state;
        logic [Instr_FPU_Total-1:0] ivec;
        logic [63:0] a;
        logic [63:0] b;
        logic [waddr_width_max-1:0] waddr;
        logic [63:0] res;
        logic [4:0] ex;
        logic [4:0] fflags;
        logic [wdog_width_max-1:0] wdog;
        logic timeout;
    } FpuIssueCtrl_registers;

    localparam FpuIssueCtrl_registers FpuIssueCtrl_r_reset = '{
        state: IDLE,
        ivec: '0,
        a: '0,
        b: '0,
        waddr: '0,
        res: '0,
        ex: '0,
        fflags: '0,
        wdog: '0,
        timeout: 1'b0
    };

endpackage

// File: rtl/river_cfg_pkg.sv
// river_cfg_pkg: core-wide configuration shared with the FPU issue sequencer
package river_cfg_pkg;

    localparam int Instr_FPU_Total = 10;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: executor request, FPU handshake, writeback and fflags signals of the issue sequencer
interface fpu_issue_ctrl_if #(
    parameter int waddr_width = 6
);
    import river_cfg_pkg::*;

    logic i_req_valid;
    logic o_req_ready;
    logic [Instr_FPU_Total-1:0] i_ivec;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic [waddr_width-1:0] i_waddr;
    logic i_flush;
    logic o_fpu_ena;
    logic [Instr_FPU_Total-1:0] o_fpu_ivec;
    logic [63:0] o_fpu_a;
    logic [63:0] o_fpu_b;
    logic i_fpu_valid;
    logic [63:0] i_fpu_res;
    logic [4:0] i_fpu_ex;
    logic o_wb_valid;
    logic i_wb_ready;
    logic [63:0] o_wb_res;
    logic [waddr_width-1:0] o_wb_waddr;
    logic [4:0] o_wb_ex;
    logic [4:0] o_fflags;
    logic i_fflags_clr;
    logic o_busy;
    logic o_timeout;

    modport slave (
        input  i_req_valid, i_ivec, i_a, i_b, i_waddr, i_flush,
        input  i_fpu_valid, i_fpu_res, i_fpu_ex, i_wb_ready, i_fflags_clr,
        output o_req_ready, o_fpu_ena, o_fpu_ivec, o_fpu_a, o_fpu_b,
        output o_wb_valid, o_wb_res, o_wb_waddr, o_wb_ex, o_fflags, o_busy, o_timeout
    );

    modport master (
        output i_req_valid, i_ivec, i_a, i_b, i_waddr, i_flush,
        output i_fpu_valid, i_fpu_res, i_fpu_ex, i_wb_ready, i_fflags_clr,
        input  o_req_ready, o_fpu_ena, o_fpu_ivec, o_fpu_a, o_fpu_b,
        input  o_wb_valid, o_wb_res, o_wb_waddr, o_wb_ex, o_fflags, o_busy, o_timeout
    );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-entry FPU issue/writeback sequencer with watchdog and sticky fflags
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int timeout_cycles = 64,
    parameter int waddr_width = 6
) (
    input logic i_clk,
    input logic i_nrst,
    fpu_issue_ctrl_if.slave bus
);

    localparam int wdog_width = $clog2(timeout_cycles);
    localparam logic [wdog_width_max-1:0] wdog_sat = wdog_width_max'((1 << wdog_width) - 1);
    localparam logic [wdog_width_max-1:0] wdog_last = wdog_width_max'(timeout_cycles - 1);

    FpuIssueCtrl_registers r;
    FpuIssueCtrl_registers rin;
    logic [wdog_width_max-1:0] wdog_nxt;
    logic expire;
    logic accept;
    logic unused_waddr_hi;

    assign wdog_nxt = (r.wdog == wdog_sat) ? r.wdog : r.wdog + wdog_width_max'(1);
    assign expire = wdog_nxt == wdog_last;
    assign accept = (r.state == HOLD) & bus.i_wb_ready & ~bus.i_flush;
    assign unused_waddr_hi = ^r.waddr;

    // Next-state, operand/result capture, watchdog and sticky flag update
    always_comb begin
        rin = r;
        rin.timeout = 1'b0;
        rin.fflags = (bus.i_fflags_clr ? 5'd0 : r.fflags) | (accept ? r.ex : 5'd0);
        case (r.state)
            IDLE: begin
                if (bus.i_req_valid && !bus.i_flush) begin
                    rin.state = ISSUE;
                    rin.ivec = bus.i_ivec;
                    rin.a = bus.i_a;
                    rin.b = bus.i_b;
                    rin.waddr = waddr_width_max'(bus.i_waddr);
                end
            end
            ISSUE: begin
                rin.wdog = '0;
                rin.state = bus.i_flush ? DRAIN : WAIT;
            end
            WAIT: begin
                rin.wdog = wdog_nxt;
                if (bus.i_flush) begin
                    rin.state = bus.i_fpu_valid ? IDLE : DRAIN;
                end else if (bus.i_fpu_valid) begin
                    rin.state = HOLD;
                    rin.res = bus.i_fpu_res;
                    rin.ex = bus.i_fpu_ex;
                end else if (expire) begin
                    rin.state = HOLD;
                    rin.res = '0;
                    rin.ex = ex_timeout;
                    rin.timeout = 1'b1;
                end
            end
            DRAIN: begin
                rin.wdog = wdog_nxt;
                if (bus.i_fpu_valid) begin
                    rin.state = IDLE;
                end else if (expire) begin
                    rin.state = IDLE;
                    rin.timeout = 1'b1;
                end
            end
            HOLD: begin
                if (bus.i_flush || bus.i_wb_ready) rin.state = IDLE;
            end
            default: rin.state = IDLE;
        endcase
    end

    // State register with asynchronous return to the reset image
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r <= FpuIssueCtrl_r_reset;
        else r <= rin;
    end

    assign bus.o_req_ready = r.state == IDLE;
    assign bus.o_fpu_ena = r.state == ISSUE;
    assign bus.o_fpu_ivec = r.ivec;
    assign bus.o_fpu_a = r.a;
    assign bus.o_fpu_b = r.b;
    assign bus.o_wb_valid = r.state == HOLD;
    assign bus.o_wb_res = r.res;
    assign bus.o_wb_waddr = r.waddr[waddr_width-1:0];
    assign bus.o_wb_ex = r.ex;
    assign bus.o_fflags = r.fflags;
    assign bus.o_busy = r.state != IDLE;
    assign bus.o_timeout = r.timeout;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for the FPU issue/writeback sequencer
module tb_fpu_issue_ctrl;
    import river_cfg_pkg::*;

    localparam int aw = 6;

    typedef struct packed {
        logic [63:0] res;
        logic [aw-1:0] waddr;
        logic [4:0] ex;
    } wb_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int checks = 0;
    int errors = 0;
    int ena_cnt = 0;
    int tmo_cnt = 0;
    wb_t exp_q[$];
    wb_t mon_e;

    fpu_issue_ctrl_if #(.waddr_width(aw)) bus ();

    fpu_issue_ctrl #(.timeout_cycles(8), .waddr_width(aw)) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops the expected writeback on every accepted HOLD cycle
    always @(negedge clk) begin
        if (nrst && bus.o_fpu_ena) ena_cnt++;
        if (nrst && bus.o_timeout) tmo_cnt++;
        if (nrst && bus.o_wb_valid && bus.i_wb_ready && !bus.i_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected got res=%h waddr=%0d, expected no writeback", bus.o_wb_res, bus.o_wb_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_res", bus.o_wb_res, mon_e.res);
                chk("wb_waddr", 64'(bus.o_wb_waddr), 64'(mon_e.waddr));
                chk("wb_ex", 64'(bus.o_wb_ex), 64'(mon_e.ex));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.o_req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 64'(bus.o_req_ready), 64'd1);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [aw-1:0] wa,
                         input logic [Instr_FPU_Total-1:0] iv);
        wait_ready();
        bus.i_req_valid = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_waddr = wa;
        bus.i_ivec = iv;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        @(negedge clk);
        chk("fpu_ena", 64'(bus.o_fpu_ena), 64'd1);
        chk("fpu_a", bus.o_fpu_a, a);
        chk("fpu_b", bus.o_fpu_b, b);
        chk("fpu_ivec", 64'(bus.o_fpu_ivec), 64'(iv));
    endtask

    task automatic fpu_reply(input int lat, input logic [63:0] res, input logic [4:0] ex);
        repeat (lat) tick();
        bus.i_fpu_valid = 1'b1;
        bus.i_fpu_res = res;
        bus.i_fpu_ex = ex;
        tick();
        bus.i_fpu_valid = 1'b0;
        bus.i_fpu_res = '0;
        bus.i_fpu_ex = '0;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [aw-1:0] wa,
                          input int lat, input logic [63:0] res, input logic [4:0] ex,
                          input int hold, input logic clr);
        exp_q.push_back('{res: res, waddr: wa, ex: ex});
        bus.i_wb_ready = (hold == 0);
        issue(a, b, wa, 10'b0000000100);
        fpu_reply(lat, res, ex);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_wb_valid", 64'(bus.o_wb_valid), 64'd1);
            chk("hold_wb_res", bus.o_wb_res, res);
            chk("hold_req_ready", 64'(bus.o_req_ready), 64'd0);
            chk("hold_fpu_a", bus.o_fpu_a, a);
            tick();
        end
        bus.i_wb_ready = 1'b1;
        bus.i_fflags_clr = clr;
        tick();
        bus.i_fflags_clr = 1'b0;
        @(negedge clk);
        chk("retire_wb_valid", 64'(bus.o_wb_valid), 64'd0);
        chk("retire_req_ready", 64'(bus.o_req_ready), 64'd1);
    endtask

    initial begin
        int e0;
        int t0;
        int seen;
        bus.i_req_valid = 1'b0;
        bus.i_ivec = '0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_waddr = '0;
        bus.i_flush = 1'b0;
        bus.i_fpu_valid = 1'b0;
        bus.i_fpu_res = '0;
        bus.i_fpu_ex = '0;
        bus.i_wb_ready = 1'b1;
        bus.i_fflags_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("rst_fpu_ena", 64'(bus.o_fpu_ena), 64'd0);
        chk("rst_wb_valid", 64'(bus.o_wb_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_timeout", 64'(bus.o_timeout), 64'd0);
        chk("rst_fflags", 64'(bus.o_fflags), 64'd0);
        chk("rst_wb_res", bus.o_wb_res, 64'd0);
        chk("rst_fpu_a", bus.o_fpu_a, 64'd0);
        tick();
        nrst = 1'b1;
        tick();

        bus.i_req_valid = 1'b1;
        bus.i_flush = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_req_ignored_busy", 64'(bus.o_busy), 64'd0);

        e0 = ena_cnt;
        run_op(64'h3FF0000000000000, 64'h4000000000000000, 6'd5, 3, 64'h4008000000000000, 5'b00000, 0, 1'b0);
        chk("basic_ena_count", 64'(ena_cnt - e0), 64'd1);
        chk("basic_fflags", 64'(bus.o_fflags), 64'd0);

        run_op(64'h1111, 64'h2222, 6'd17, 1, 64'hDEADBEEFCAFEF00D, 5'b00000, 10, 1'b0);

        run_op(64'h3, 64'h4, 6'd1, 2, 64'h7, 5'b00001, 0, 1'b0);
        run_op(64'h5, 64'h6, 6'd2, 1, 64'hB, 5'b00100, 0, 1'b0);
        chk("sticky_or", 64'(bus.o_fflags), 64'd5);
        run_op(64'h7, 64'h8, 6'd3, 1, 64'hF, 5'b01000, 0, 1'b1);
        chk("sticky_clr_with_accept", 64'(bus.o_fflags), 64'b01000);

        exp_q.push_back('{res: 64'd0, waddr: 6'd9, ex: 5'b10000});
        bus.i_wb_ready = 1'b1;
        t0 = tmo_cnt;
        issue(64'hAAAA, 64'hBBBB, 6'd9, 10'b0000100000);
        seen = -1;
        for (int k = 1; k <= 12 && seen < 0; k++) begin
            tick();
            @(negedge clk);
            if (bus.o_timeout) seen = k;
        end
        chk("wdog_pulse_cycle", 64'(seen), 64'd8);
        chk("wdog_wb_valid", 64'(bus.o_wb_valid), 64'd1);
        chk("wdog_wb_res", bus.o_wb_res, 64'd0);
        chk("wdog_wb_ex", 64'(bus.o_wb_ex), 64'b10000);
        tick();
        @(negedge clk);
        chk("wdog_pulse_count", 64'(tmo_cnt - t0), 64'd1);
        chk("wdog_fflags", 64'(bus.o_fflags), 64'b11000);
        chk("wdog_req_ready", 64'(bus.o_req_ready), 64'd1);

        bus.i_fflags_clr = 1'b1;
        tick();
        bus.i_fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_clr", 64'(bus.o_fflags), 64'd0);

        t0 = tmo_cnt;
        issue(64'h1, 64'h2, 6'd12, 10'b0000000001);
        tick();
        bus.i_flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_busy", 64'(bus.o_busy), 64'd1);
        tick();
        bus.i_flush = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("drain_busy", 64'(bus.o_busy), 64'd1);
            chk("drain_wb_valid", 64'(bus.o_wb_valid), 64'd0);
            tick();
        end
        bus.i_fpu_valid = 1'b1;
        bus.i_fpu_res = 64'h1234;
        bus.i_fpu_ex = 5'b00010;
        @(negedge clk);
        chk("drain_last_busy", 64'(bus.o_busy), 64'd1);
        tick();
        bus.i_fpu_valid = 1'b0;
        bus.i_fpu_ex = '0;
        @(negedge clk);
        chk("drain_done_ready", 64'(bus.o_req_ready), 64'd1);
        chk("drain_done_busy", 64'(bus.o_busy), 64'd0);
        chk("drain_fflags", 64'(bus.o_fflags), 64'd0);
        chk("drain_no_timeout", 64'(tmo_cnt - t0), 64'd0);

        issue(64'h9, 64'hA, 6'd20, 10'b0000000010);
        fpu_reply(1, 64'h55, 5'b00010);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        @(negedge clk);
        chk("hold_flush_ready", 64'(bus.o_req_ready), 64'd1);
        chk("hold_flush_fflags", 64'(bus.o_fflags), 64'd0);

        bus.i_wb_ready = 1'b0;
        issue(64'hFEED, 64'hBEEF, 6'd33, 10'b1000000000);
        fpu_reply(2, 64'h77, 5'b00001);
        @(negedge clk);
        chk("pre_reset_wb_valid", 64'(bus.o_wb_valid), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("async_rst_wb_valid", 64'(bus.o_wb_valid), 64'd0);
        chk("async_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("async_rst_wb_res", bus.o_wb_res, 64'd0);
        chk("async_rst_wb_waddr", 64'(bus.o_wb_waddr), 64'd0);
        chk("async_rst_fpu_a", bus.o_fpu_a, 64'd0);
        chk("async_rst_fflags", 64'(bus.o_fflags), 64'd0);
        tick();
        nrst = 1'b1;
        bus.i_wb_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Single-entry issue/writeback sequencer sitting directly upstream of the double-precision FPU top. It accepts one FPU instruction at a time from the executor, drives a one-cycle enable with latched operands into the FPU, and captures result plus exception flags. It then holds them for the writeback port and accumulates sticky fflags for the CSR block. A watchdog turns a hung FPU operation into a flagged completion.

## Interface
Parameters:
- timeout_cycles, 64, WAIT-state cycles before watchdog completion; legal range 2..1023.
- waddr_width, 6, destination register tag width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (i_clk, i_nrst).
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_req_valid  in  1  executor request.
- o_req_ready  out  1  sequencer can accept.
- i_ivec  in  Instr_FPU_Total  one-hot FPU instruction vector.
- i_a, i_b  in  64  operands.
- i_waddr  in  waddr_width  destination tag.
- i_flush  in  1  pipeline flush; discard in-flight op.
- o_fpu_ena  out  1  one-cycle start pulse to FPU.
- o_fpu_ivec  out  Instr_FPU_Total  latched ivec.
- o_fpu_a, o_fpu_b  out  64  latched operands.
- i_fpu_valid  in  1  FPU result valid, one cycle.
- i_fpu_res  in  64  FPU result.
- i_fpu_ex  in  5  {invalidop, divbyzero, overflow, underflow, inexact}.
- o_wb_valid  out  1  result held for writeback.
- i_wb_ready  in  1  writeback accepted.
- o_wb_res  out  64  held result.
- o_wb_waddr  out  waddr_width  held tag.
- o_wb_ex  out  5  held exception bits, same order as i_fpu_ex.
- o_fflags  out  5  sticky accumulated flags.
- i_fflags_clr  in  1  clear sticky flags.
- o_busy  out  1  state != IDLE.
- o_timeout  out  1  one-cycle watchdog pulse.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- IDLE: o_req_ready=1. On i_req_valid & ~i_flush: latch ivec/a/b/waddr, go ISSUE. Request with i_flush high is ignored.
- ISSUE: o_fpu_ena=1 for exactly this cycle; clear watchdog; go WAIT. On i_flush, go DRAIN; the pulse is still emitted.
- WAIT: increment watchdog.
  - On i_fpu_valid: latch res/ex, go HOLD.
  - When counter reaches timeout_cycles-1 without i_fpu_valid: o_timeout=1, res=0, ex=5'b10000, go HOLD.
  - On i_flush: go DRAIN, or IDLE if i_fpu_valid is high in the same cycle.
- DRAIN: wait for i_fpu_valid or watchdog expiry, then IDLE; result discarded, no fflags update, o_timeout still pulses on expiry. Guarantees no new op starts while the FPU is busy.
- HOLD: o_wb_valid=1. On i_wb_ready go IDLE and OR o_wb_ex into fflags. On i_flush go IDLE, discard, no fflags update; flush wins over simultaneous i_wb_ready.
- fflags next = (i_fflags_clr ? 0 : fflags) | (wb accept ? o_wb_ex : 0). An accept in the clear cycle survives.
- o_fpu_a/b/ivec are stable from ISSUE until the next IDLE accept.
- Watchdog width: $clog2(timeout_cycles); saturates, never wraps.

## Timing
- Reset values: state IDLE, all latched data 0, fflags 0. Outputs: o_req_ready=1, every other output 0.
- Request accepted at edge T. ISSUE (o_fpu_ena) during T+1. Earliest i_fpu_valid during T+2. HOLD (o_wb_valid) from T+3.
- Minimum op period: 4 cycles (IDLE, ISSUE, WAIT, HOLD). No back-to-back acceptance.
- o_req_ready and o_wb_valid are pure state decodes, with no combinational path from i_req_valid or i_wb_ready.
- Reset mid-operation returns immediately to the reset values. The FPU is reset by the same i_nrst.

## Structure
- fpu_issue_ctrl_pkg holds:
  - state encoding constants (3-bit);
  - FpuIssueCtrl_registers struct (state, ivec, a, b, waddr, res, ex, fflags, wdog, timeout);
  - FpuIssueCtrl_r_reset constant.
- Instr_FPU_Total comes from river_cfg_pkg.
- No sub-module; a single comb/seq pair.

## Test plan
- Basic op: req a=0x3FF0000000000000, b=0x4000000000000000. FPU returns res=0x4008000000000000, ex=0 three cycles after ena. Expect exactly one ena pulse, o_wb_valid with matching res/waddr, fflags=0.
- Backpressure: hold i_wb_ready=0 for 10 cycles. o_wb_valid and o_wb_res stay stable and o_req_ready=0 throughout; the op retires on the first ready.
- Sticky flags: two ops with ex=5'b00001, then 5'b00100. Expect fflags=5'b00101. Asserting i_fflags_clr in the same cycle as a third accept with ex=5'b01000 gives fflags=5'b01000.
- Watchdog: timeout_cycles=8, FPU never valid. Expect o_timeout pulse 8 cycles after ena, o_wb_res=0, o_wb_ex=5'b10000.
- Flush in WAIT: flush 1 cycle after ena; FPU valid arrives 5 cycles later. Expect o_busy=1 until then, o_wb_valid never asserted, fflags unchanged, then o_req_ready=1.
- Reset mid-op: deassert i_nrst in HOLD. All outputs return to reset values asynchronously, and o_req_ready=1 after release.
